// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates I-cache and D-cache line requests onto a single
// memory port, with one transaction outstanding at a time.
//
// Ports:
//   clk, reset           - clock, synchronous active-high reset
//   reqI, reqAddrI       - I-side miss request and line address
//   reqD, reqAddrD       - D-side request and line address
//   reqWrD, wrLineD      - D-side writeback flag and data
//   lineI/lineD, rdyI/rdyD, ackI/ackD - per-side response, valid, consume
//   mem_req, mem_addr, mem_wr, mem_wdata, mem_ack, mem_rdata - memory port
//   busy                 - high whenever the arbiter is not idle
module mem_arbiter #(
  parameter int TAG_W  = 26,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reqI,
  input  logic [TAG_W-1:0]  reqAddrI,
  input  logic              reqD,
  input  logic [TAG_W-1:0]  reqAddrD,
  input  logic              reqWrD,
  input  logic [LINE_W-1:0] wrLineD,
  output logic [LINE_W-1:0] lineI,
  output logic [LINE_W-1:0] lineD,
  output logic              rdyI,
  output logic              rdyD,
  input  logic              ackI,
  input  logic              ackD,
  output logic              mem_req,
  output logic [TAG_W-1:0]  mem_addr,
  output logic              mem_wr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                last_grant_q;   // 1 = D side was granted last
  logic                gnt_d_q;        // 1 = current transaction belongs to D
  logic [TAG_W-1:0]    addr_q;
  logic                wr_q;
  logic [LINE_W-1:0]   wdata_q;
  logic [LINE_W-1:0]   lineI_q;
  logic [LINE_W-1:0]   lineD_q;

  logic                grant_fire;
  logic                win_d;          // winner of this cycle's arbitration, 1 = D

  always_comb begin
    state_d    = state_q;
    grant_fire = 1'b0;
    win_d      = last_grant_q;
    case (state_q)
      IDLE: begin
        if (reqI || reqD) begin
          grant_fire = 1'b1;
          // Round robin on contention: the side not granted last wins.
          if (reqI && reqD) win_d = ~last_grant_q;
          else              win_d = reqD;
          state_d = MEM;
        end
      end
      MEM: begin
        if (mem_ack) state_d = RESP;
      end
      RESP: begin
        if (gnt_d_q ? ackD : ackI) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      gnt_d_q      <= 1'b0;
      addr_q       <= '0;
      wr_q         <= 1'b0;
      wdata_q      <= '0;
      lineI_q      <= '0;
      lineD_q      <= '0;
    end else begin
      state_q <= state_d;
      if (grant_fire) begin
        gnt_d_q      <= win_d;
        last_grant_q <= win_d;
        addr_q       <= win_d ? reqAddrD : reqAddrI;
        wr_q         <= win_d & reqWrD;
        wdata_q      <= win_d ? wrLineD : '0;
      end
      if (state_q == MEM && mem_ack && !wr_q) begin
        if (gnt_d_q) lineD_q <= mem_rdata;
        else         lineI_q <= mem_rdata;
      end
    end
  end

  assign mem_req   = (state_q == MEM);
  assign mem_addr  = addr_q;
  assign mem_wr    = (state_q == MEM) & wr_q;
  assign mem_wdata = wdata_q;
  assign rdyI      = (state_q == RESP) & ~gnt_d_q;
  assign rdyD      = (state_q == RESP) &  gnt_d_q;
  assign busy      = (state_q != IDLE);
  assign lineI     = lineI_q;
  assign lineD     = lineD_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  localparam int TAG_W  = 26;
  localparam int LINE_W = 128;

  localparam logic [LINE_W-1:0] PA5 = {16{8'hA5}};
  localparam logic [LINE_W-1:0] P5A = {16{8'h5A}};
  localparam logic [LINE_W-1:0] PFF = {16{8'hFF}};
  localparam logic [LINE_W-1:0] P3C = {16{8'h3C}};
  localparam logic [LINE_W-1:0] Z   = '0;

  logic              clk = 1'b0;
  logic              reset, reqI, reqD, reqWrD, ackI, ackD, mem_ack;
  logic [TAG_W-1:0]  reqAddrI, reqAddrD;
  logic [LINE_W-1:0] wrLineD, mem_rdata;
  logic [LINE_W-1:0] lineI, lineD, mem_wdata;
  logic              rdyI, rdyD, mem_req, mem_wr, busy;
  logic [TAG_W-1:0]  mem_addr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.TAG_W(TAG_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .reset(reset),
    .reqI(reqI), .reqAddrI(reqAddrI),
    .reqD(reqD), .reqAddrD(reqAddrD), .reqWrD(reqWrD), .wrLineD(wrLineD),
    .lineI(lineI), .lineD(lineD), .rdyI(rdyI), .rdyD(rdyD),
    .ackI(ackI), .ackD(ackD),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  typedef struct {
    logic              rst, rI, rD, wr, akI, akD, mack;
    logic [TAG_W-1:0]  aI, aD;
    logic [LINE_W-1:0] wl, rdata;
    logic              e_req, e_wr, e_rdyI, e_rdyD, e_busy;
    logic [TAG_W-1:0]  e_addr;
    logic [LINE_W-1:0] e_wdata, e_lineI, e_lineD;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, rI, input logic [TAG_W-1:0] aI,
                     input logic rD, input logic [TAG_W-1:0] aD,
                     input logic wr, input logic [LINE_W-1:0] wl,
                     input logic akI, akD, mack, input logic [LINE_W-1:0] rdata,
                     input logic e_req, input logic [TAG_W-1:0] e_addr,
                     input logic e_wr, input logic [LINE_W-1:0] e_wdata,
                     input logic e_rdyI, e_rdyD, e_busy,
                     input logic [LINE_W-1:0] e_lineI, e_lineD);
    vec_t v;
    v.rst = rst; v.rI = rI; v.aI = aI; v.rD = rD; v.aD = aD; v.wr = wr;
    v.wl = wl; v.akI = akI; v.akD = akD; v.mack = mack; v.rdata = rdata;
    v.e_req = e_req; v.e_addr = e_addr; v.e_wr = e_wr; v.e_wdata = e_wdata;
    v.e_rdyI = e_rdyI; v.e_rdyD = e_rdyD; v.e_busy = e_busy;
    v.e_lineI = e_lineI; v.e_lineD = e_lineD;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [LINE_W-1:0] got,
                     input logic [LINE_W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  task automatic idle_inputs();
    reset = 1'b0; reqI = 1'b0; reqD = 1'b0; reqWrD = 1'b0;
    ackI = 1'b0; ackD = 1'b0; mem_ack = 1'b0;
    reqAddrI = '0; reqAddrD = '0; wrLineD = '0; mem_rdata = '0;
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    step();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Drive a mem_ack pulse with data in the current (MEM) cycle.
  task automatic pulse_ack(input logic [LINE_W-1:0] d);
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = d;
    step();
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = '0;
  endtask

  initial begin
    idle_inputs();
    //   rst rI aI        rD aD       wr wl   akI akD mk rdata  | req addr     wr wdata rdyI rdyD busy lineI lineD
    add(1, 0, 26'h0,    0, 26'h0,  0, Z,   0, 0, 0, Z,     0, 26'h0,   0, Z,   0, 0, 0, Z,   Z);
    add(0, 1, 26'h100,  0, 26'h0,  0, Z,   0, 0, 0, Z,     1, 26'h100, 0, Z,   0, 0, 1, Z,   Z);
    add(0, 1, 26'h3FF,  0, 26'h0,  0, Z,   0, 0, 0, Z,     1, 26'h100, 0, Z,   0, 0, 1, Z,   Z);
    add(0, 1, 26'h3FF,  1, 26'h7,  0, Z,   0, 0, 0, Z,     1, 26'h100, 0, Z,   0, 0, 1, Z,   Z);
    add(0, 1, 26'h3FF,  0, 26'h0,  0, Z,   0, 0, 1, PA5,   0, 26'h100, 0, Z,   1, 0, 1, PA5, Z);
    add(0, 1, 26'h3FF,  0, 26'h0,  0, Z,   0, 1, 0, Z,     0, 26'h100, 0, Z,   1, 0, 1, PA5, Z);
    add(0, 0, 26'h0,    0, 26'h0,  0, Z,   1, 0, 0, Z,     0, 26'h100, 0, Z,   0, 0, 0, PA5, Z);
    add(0, 0, 26'h0,    0, 26'h0,  0, Z,   1, 0, 1, PFF,   0, 26'h100, 0, Z,   0, 0, 0, PA5, Z);
    add(0, 0, 26'h0,    1, 26'h2,  1, P5A, 0, 0, 0, Z,     1, 26'h2,   1, P5A, 0, 0, 1, PA5, Z);
    add(0, 0, 26'h0,    1, 26'h9,  1, PFF, 0, 0, 1, P3C,   0, 26'h2,   0, P5A, 0, 1, 1, PA5, Z);
    add(0, 0, 26'h0,    0, 26'h0,  0, Z,   0, 1, 0, Z,     0, 26'h2,   0, P5A, 0, 0, 0, PA5, Z);
    add(0, 0, 26'h0,    1, 26'h55, 0, Z,   0, 0, 0, Z,     1, 26'h55,  0, Z,   0, 0, 1, PA5, Z);
    add(0, 0, 26'h0,    1, 26'h55, 0, Z,   0, 0, 1, P3C,   0, 26'h55,  0, Z,   0, 1, 1, PA5, P3C);
    add(0, 0, 26'h0,    0, 26'h0,  0, Z,   0, 1, 0, Z,     0, 26'h55,  0, Z,   0, 0, 0, PA5, P3C);

    foreach (vecs[i]) begin
      @(negedge clk);
      reset = vecs[i].rst; reqI = vecs[i].rI; reqAddrI = vecs[i].aI;
      reqD = vecs[i].rD; reqAddrD = vecs[i].aD; reqWrD = vecs[i].wr;
      wrLineD = vecs[i].wl; ackI = vecs[i].akI; ackD = vecs[i].akD;
      mem_ack = vecs[i].mack; mem_rdata = vecs[i].rdata;
      step();
      chk($sformatf("v%0d mem_req", i),   LINE_W'(mem_req),   LINE_W'(vecs[i].e_req));
      chk($sformatf("v%0d mem_addr", i),  LINE_W'(mem_addr),  LINE_W'(vecs[i].e_addr));
      chk($sformatf("v%0d mem_wr", i),    LINE_W'(mem_wr),    LINE_W'(vecs[i].e_wr));
      chk($sformatf("v%0d mem_wdata", i), mem_wdata,          vecs[i].e_wdata);
      chk($sformatf("v%0d rdyI", i),      LINE_W'(rdyI),      LINE_W'(vecs[i].e_rdyI));
      chk($sformatf("v%0d rdyD", i),      LINE_W'(rdyD),      LINE_W'(vecs[i].e_rdyD));
      chk($sformatf("v%0d busy", i),      LINE_W'(busy),      LINE_W'(vecs[i].e_busy));
      chk($sformatf("v%0d lineI", i),     lineI,              vecs[i].e_lineI);
      chk($sformatf("v%0d lineD", i),     lineD,              vecs[i].e_lineD);
    end

    // Round robin: both requests held high from reset -> I, D, I.
    do_reset();
    reqI = 1'b1; reqD = 1'b1; reqAddrI = 26'h11; reqAddrD = 26'h22;
    step();
    chk("rr1 addr", LINE_W'(mem_addr), LINE_W'(26'h11));
    chk("rr1 req",  LINE_W'(mem_req),  LINE_W'(1'b1));
    pulse_ack(PA5);
    chk("rr1 rdyI", LINE_W'(rdyI), LINE_W'(1'b1));
    chk("rr1 rdyD", LINE_W'(rdyD), LINE_W'(1'b0));
    ackI = 1'b1; step(); @(negedge clk); ackI = 1'b0;
    chk("rr1 idle busy", LINE_W'(busy), LINE_W'(1'b0));
    chk("rr1 idle req",  LINE_W'(mem_req), LINE_W'(1'b0));
    step();
    chk("rr2 addr", LINE_W'(mem_addr), LINE_W'(26'h22));
    pulse_ack(P3C);
    chk("rr2 rdyD",  LINE_W'(rdyD), LINE_W'(1'b1));
    chk("rr2 lineD", lineD, P3C);
    ackD = 1'b1; step(); @(negedge clk); ackD = 1'b0;
    step();
    chk("rr3 addr", LINE_W'(mem_addr), LINE_W'(26'h11));
    chk("rr3 req",  LINE_W'(mem_req),  LINE_W'(1'b1));
    pulse_ack(PFF);
    reqI = 1'b0; reqD = 1'b0;
    chk("rr3 lineI", lineI, PFF);
    ackI = 1'b1; step(); @(negedge clk); ackI = 1'b0;

    // Unacked I response held while the wrong-side ack is asserted.
    reqI = 1'b1; reqAddrI = 26'h40;
    step();
    @(negedge clk); reqI = 1'b0;
    pulse_ack(P5A);
    ackD = 1'b1;
    for (int unsigned k = 0; k < 20; k++) begin
      step();
      chk($sformatf("hold%0d rdyI", k),  LINE_W'(rdyI), LINE_W'(1'b1));
      chk($sformatf("hold%0d lineI", k), lineI, P5A);
      chk($sformatf("hold%0d busy", k),  LINE_W'(busy), LINE_W'(1'b1));
    end
    @(negedge clk); ackD = 1'b0; ackI = 1'b1;
    step();
    @(negedge clk); ackI = 1'b0;
    chk("hold release busy", LINE_W'(busy), LINE_W'(1'b0));

    // Reset while in MEM, then a stale mem_ack two cycles later.
    reqI = 1'b1; reqAddrI = 26'h77;
    step();
    chk("rstmem req", LINE_W'(mem_req), LINE_W'(1'b1));
    @(negedge clk); reqI = 1'b0; reset = 1'b1;
    step();
    @(negedge clk); reset = 1'b0;
    mem_ack = 1'b1; mem_rdata = PFF;
    step();
    @(negedge clk); mem_ack = 1'b0; mem_rdata = '0;
    for (int unsigned k = 0; k < 3; k++) begin
      chk($sformatf("rstmem%0d req", k),   LINE_W'(mem_req),  LINE_W'(1'b0));
      chk($sformatf("rstmem%0d rdyI", k),  LINE_W'(rdyI),     LINE_W'(1'b0));
      chk($sformatf("rstmem%0d rdyD", k),  LINE_W'(rdyD),     LINE_W'(1'b0));
      chk($sformatf("rstmem%0d busy", k),  LINE_W'(busy),     LINE_W'(1'b0));
      chk($sformatf("rstmem%0d addr", k),  LINE_W'(mem_addr), LINE_W'(1'b0));
      chk($sformatf("rstmem%0d lineI", k), lineI, Z);
      chk($sformatf("rstmem%0d lineD", k), lineD, Z);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TAG_W, default 26, line-address (tag) width of a memory request.
REQ-002 Parameter LINE_W, default 128, cache-line width in bits.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 reqI  input  1  I-cache miss request, held high until rdyI.
REQ-006 reqAddrI  input  TAG_W  I-cache miss line address.
REQ-007 reqD  input  1  D-cache request (fill or writeback), held high until rdyD.
REQ-008 reqAddrD  input  TAG_W  D-cache line address.
REQ-009 reqWrD  input  1  1 = writeback of wrLineD, 0 = fill.
REQ-010 wrLineD  input  LINE_W  writeback data.
REQ-011 lineI / lineD  output  LINE_W  returned line to I / D side.
REQ-012 rdyI / rdyD  output  1  line valid / write complete for I / D side.
REQ-013 ackI / ackD  input  1  requester has consumed the response (data_filled_ack).
REQ-014 mem_req  output  1  request to the single memory port.
REQ-015 mem_addr  output  TAG_W  memory line address.
REQ-016 mem_wr  output  1  memory write enable.
REQ-017 mem_wdata  output  LINE_W  memory write data.
REQ-018 mem_ack  input  1  one-cycle memory completion pulse.
REQ-019 mem_rdata  input  LINE_W  read data, valid with mem_ack.
REQ-020 busy  output  1  high in every state except IDLE.

Function
REQ-021 The FSM SHALL have states IDLE, MEM, RESP; at most one transaction is outstanding.
REQ-022 reqI/reqD SHALL be sampled only in IDLE; in all other states they are ignored.
REQ-023 In IDLE with exactly one request high, that requester SHALL be granted and the FSM SHALL enter MEM on the next edge.
REQ-024 In IDLE with both requests high, the requester not granted last SHALL win (round robin); a last_grant bit SHALL update on each grant.
REQ-025 On grant, address, write flag and write data of the winner SHALL be latched; later changes on request inputs SHALL not affect the transaction.
REQ-026 In MEM, mem_req SHALL be high and mem_addr/mem_wr/mem_wdata SHALL drive the latched values; mem_wr SHALL be 0 for I-side grants.
REQ-027 mem_req SHALL rise on the edge after the grant decision (1-cycle request-to-memory latency).
REQ-028 mem_ack SHALL be honoured only in MEM; on it, mem_rdata SHALL be registered into lineI or lineD of the granted side (not for writes) and the FSM SHALL enter RESP.
REQ-029 In RESP, only the granted side's rdy SHALL be high; mem_req SHALL be low.
REQ-030 In RESP, the granted side's ack SHALL return the FSM to IDLE on the next edge; the other side's ack and any ack outside RESP SHALL be ignored.
REQ-031 A response SHALL hold rdy and line stable indefinitely until acked (no timeout).
REQ-032 On ack, the FSM SHALL spend at least one cycle in IDLE before the next mem_req.
REQ-033 lineI/lineD SHALL retain their last value outside RESP; line data for a write response is unchanged.

Reset
REQ-034 Reset SHALL force IDLE and clear mem_req, mem_wr, rdyI, rdyD, busy, mem_addr, mem_wdata, lineI, lineD to 0.
REQ-035 Reset SHALL set last_grant to D so that the first simultaneous request grants I.
REQ-036 Reset in MEM or RESP SHALL abandon the transaction; a mem_ack arriving after reset SHALL be ignored.

Verification
REQ-037 reqI=1, addr 0x100 at cycle 0 -> mem_req=1, mem_addr=0x100, mem_wr=0 at cycle 1; mem_ack with data 0xA5.. at cycle 4 -> rdyI=1, lineI=0xA5.. at cycle 5; ackI at 6 -> busy=0 at 7.
REQ-038 reqI and reqD both high after reset -> I granted; keep both high through completion -> D granted next, then I again (alternation).
REQ-039 reqD=1, reqWrD=1, wrLineD=0x5A.., addr 0x2 -> mem_wr=1, mem_wdata=0x5A..; after mem_ack, rdyD=1, lineD unchanged.
REQ-040 Hold response unacked 20 cycles while asserting ackD during an I transaction -> rdyI stays 1, lineI stable, FSM stays RESP.
REQ-041 Reset asserted in MEM, mem_ack pulsed 2 cycles later -> all outputs 0, no rdy pulse, busy=0.
